main_mem_if: RTL and testbench
==============================

Name: main_mem_if

Overview:
- Main-memory model and interface for the two-way set-associative cache controller's memory bus.
- Sits directly downstream of the cache controller and services its byte-wide read (refill) and write (write-back) requests.
- Each access takes a programmable number of wait states and completes through the readyMem handshake.
- Used both as the synthesizable memory stand-in and as the bench memory for cache verification.

Parameters:
- adrWIDTH, 16: width of adrMM.
- dataWIDTH, 8: width of dataMM, one byte.
- memAW, 16: log2 of storage depth in bytes. Only adrMM[memAW-1:0] is used; upper bits are ignored.
- LATENCY, 4: number of wait cycles per access. Legal range 1..15; 0 is treated as 1.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous active-low reset
- adrMM  in  adrWIDTH  byte address from the cache controller
- dataMM  inout  dataWIDTH  bidirectional data bus
- readMem  in  1  read request
- writeMem  in  1  write request
- readyMem  out  1  high = idle/accepting, or access complete
- busErr  out  1  sticky flag: readMem and writeMem were asserted together
- rdCount  out  16  completed reads, wraps at 16'hFFFF
- wrCount  out  16  completed writes, wraps at 16'hFFFF

Behaviour:
- Single clock domain. All state updates on posedge CLK. RST is sampled only at the clock edge.
- Reset values: state=IDLE, readyMem=1, busErr=0, rdCount=0, wrCount=0, dataMM=Z.
- Storage contents are not reset.
- Reset asserted mid-access aborts the access:
  - no write is committed;
  - the FSM returns to IDLE on the next edge.
- States are IDLE, ACCESS, DONE.

IDLE:
- readyMem=1, dataMM=Z.
- On an edge with writeMem=1, latch adrMM and dataMM (write data), set op=WR, load cnt=LATENCY-1, and go to ACCESS.
- Else, on an edge with readMem=1, latch adrMM, set op=RD, load cnt=LATENCY-1, and go to ACCESS.
- If readMem and writeMem are both high, the write wins and busErr is set to 1. busErr stays set until reset.

ACCESS:
- readyMem=0, dataMM=Z.
- Each edge decrements cnt.
- On the edge where cnt==0, go to DONE.
- ACCESS therefore lasts exactly LATENCY cycles.
- Reads fetch mem[adr] into the output register no later than the edge that enters DONE.
- Request inputs are ignored in this state.

DONE (exactly 1 cycle):
- readyMem=1.
- RD: dataMM is driven with the read byte for the whole cycle; rdCount increments on the exit edge.
- WR: mem[adr] is written with the latched byte on the exit edge; dataMM stays Z; wrCount increments.
- Always returns to IDLE. A request held through DONE is not accepted until IDLE.
- Consequence: a request continuously asserted is serviced again after one IDLE cycle.

Timing and bus rules:
- Latency from accept edge to DONE = LATENCY cycles; full occupancy = LATENCY+2 cycles including IDLE.
- dataMM is driven only in DONE with op=RD. At all other times it is Z, so the controller may drive it.
- Read-after-write to the same address returns the new byte, because the write commits before the next accept.

Optional Feature:
- Macro: MAIN_MEM_PARITY_EN
- When defined:
  - each stored byte carries an even-parity bit, computed on write;
  - on a read, the bit is checked in DONE;
  - a mismatch sets the added output parErr (1 bit, sticky, reset 0);
  - input injPar (1 bit), when high at a write commit, stores the inverted parity bit.
- When undefined:
  - no parity storage;
  - parErr and injPar ports are absent;
  - behaviour is otherwise identical.

Decomposition:
- Package main_mem_pkg holds:
  - the state encoding localparams IDLE=2'b00, ACCESS=2'b01, DONE=2'b10;
  - op encodings RD=1'b0, WR=1'b1;
  - the counter width constant CNT_W=4.
- One natural sub-module: mm_byte_array.
  - Single port, synchronous write and synchronous read, depth 2^memAW.
  - Optional parity bit lane.
- The FSM, counter, tristate and statistics stay in main_mem_if.

Test Plan:
- Reset, then writeMem=1 with adrMM=16'h0010 and dataMM=8'hA5 in IDLE → readyMem=0 for 4 cycles, then 1 for the DONE cycle; wrCount=1.
- Next, readMem=1 with adrMM=16'h0010 → after 4 low cycles, readyMem=1 with dataMM=8'hA5 in DONE; Z on the following cycle; rdCount=1.
- readMem=1 and writeMem=1 together, adrMM=16'h0020, dataMM=8'h3C → a write is performed and busErr=1. A later read of 16'h0020 returns 8'h3C; busErr stays 1.
- RST=0 asserted during the 2nd ACCESS cycle of a write of 8'hFF to 16'h0030 → the next cycle is IDLE with readyMem=1. A later read of 16'h0030 does not return 8'hFF (preloaded 8'h00 returns 8'h00).
- LATENCY=1 instance with readMem held high for 9 cycles → readyMem pattern 0,1,1 repeating; rdCount=3.
- With MAIN_MEM_PARITY_EN: write 8'h01 with injPar=1, then read → parErr=1 in the DONE cycle, sticky thereafter.

Source files
------------

// File: rtl/main_mem_pkg.sv
// Shared definitions for the main-memory bus model: FSM state encoding,
// access-type encoding, wait-state counter width and latency clamping.
package main_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    localparam int CNT_W = 4;

    // Zero wait states would collapse ACCESS, so 0 is treated as 1; the
    // counter cannot hold more than 15.
    function automatic int eff_latency(input int lat);
        if (lat < 1) begin
            return 1;
        end else if (lat > 15) begin
            return 15;
        end
        return lat;
    endfunction

endpackage

// File: rtl/mm_byte_array.sv
// Byte-wide single-port storage with synchronous write and synchronous read.
// Contents are never reset. Optional macro MAIN_MEM_PARITY_EN adds a
// one-bit parity lane stored next to each byte.
module mm_byte_array
    import main_mem_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
`ifdef MAIN_MEM_PARITY_EN
    ,
    input  logic          wpar_i,
    output logic          rpar_o
`endif
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Write port and registered read port share one address.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

`ifdef MAIN_MEM_PARITY_EN
    logic par_q [2**AW];
    logic rpar_q;

    // Parity lane follows the byte lane exactly.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            par_q[addr_i] <= wpar_i;
        end
        if (re_i) begin
            rpar_q <= par_q[addr_i];
        end
    end

    assign rpar_o = rpar_q;
`endif

endmodule

// File: rtl/main_mem_if.sv
// Main-memory bus model for the cache controller: byte reads and writes
// with a fixed number of wait states, readyMem handshake, sticky bus-error
// flag and completion counters. Optional macro MAIN_MEM_PARITY_EN adds
// per-byte even parity with injPar/parErr ports.
//
// state  | meaning
// IDLE   | ready, accepting a request (write wins over read)
// ACCESS | wait states, cnt counts LATENCY-1 down to 0
// DONE   | one-cycle completion: read byte on the bus, or write commit
module main_mem_if
    import main_mem_pkg::*;
#(
    parameter int adrWIDTH  = 16,
    parameter int dataWIDTH = 8,
    parameter int memAW     = 16,
    parameter int LATENCY   = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [adrWIDTH-1:0]  adrMM,
    inout  wire  [dataWIDTH-1:0] dataMM,
    input  logic                 readMem,
    input  logic                 writeMem,
    output logic                 readyMem,
    output logic                 busErr,
    output logic [15:0]          rdCount,
    output logic [15:0]          wrCount
`ifdef MAIN_MEM_PARITY_EN
    ,
    output logic                 parErr,
    input  logic                 injPar
`endif
);

    localparam int LAT_EFF = eff_latency(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_EFF - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 op_q, op_d;
    logic [memAW-1:0]     adr_q, adr_d;
    logic [dataWIDTH-1:0] wdata_q, wdata_d;
    logic                 busErr_q, busErr_d;
    logic [15:0]          rdCount_q, rdCount_d;
    logic [15:0]          wrCount_q, wrCount_d;

    logic                 mem_we;
    logic                 mem_re;
    logic                 drive_rd;
    logic [dataWIDTH-1:0] rdata;

    // Next-state, handshake and statistics for the three-state access FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        adr_d     = adr_q;
        wdata_d   = wdata_q;
        busErr_d  = busErr_q;
        rdCount_d = rdCount_q;
        wrCount_d = wrCount_q;
        readyMem  = 1'b1;
        case (state_q)
            IDLE: begin
                if (writeMem) begin
                    state_d = ACCESS;
                    op_d    = WR;
                    cnt_d   = CNT_LOAD;
                    adr_d   = adrMM[memAW-1:0];
                    wdata_d = dataMM;
                    if (readMem) begin
                        busErr_d = 1'b1;
                    end
                end else if (readMem) begin
                    state_d = ACCESS;
                    op_d    = RD;
                    cnt_d   = CNT_LOAD;
                    adr_d   = adrMM[memAW-1:0];
                end
            end
            ACCESS: begin
                readyMem = 1'b0;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (op_q == RD) begin
                    rdCount_d = rdCount_q + 16'd1;
                end else begin
                    wrCount_d = wrCount_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; reset mid-access drops straight back to IDLE.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= IDLE;
            busErr_q  <= 1'b0;
            rdCount_q <= 16'd0;
            wrCount_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            busErr_q  <= busErr_d;
            rdCount_q <= rdCount_d;
            wrCount_q <= wrCount_d;
        end
    end

    // Request latches and wait counter need no reset; IDLE reloads them.
    always_ff @(posedge CLK) begin
        cnt_q   <= cnt_d;
        op_q    <= op_d;
        adr_q   <= adr_d;
        wdata_q <= wdata_d;
    end

    // Commit is gated by RST so a reset landing in DONE leaves memory intact.
    assign mem_we   = (state_q == DONE) && (op_q == WR) && RST;
    assign mem_re   = (state_q == ACCESS);
    assign drive_rd = (state_q == DONE) && (op_q == RD);

    assign dataMM  = drive_rd ? rdata : {dataWIDTH{1'bz}};
    assign busErr  = busErr_q;
    assign rdCount = rdCount_q;
    assign wrCount = wrCount_q;

`ifdef MAIN_MEM_PARITY_EN
    logic wpar;
    logic rpar;
    logic par_bad;
    logic parErr_q;

    // Even parity: stored bit equals XOR of the byte unless injected.
    assign wpar    = (^wdata_q) ^ injPar;
    assign par_bad = drive_rd && ((^rdata) != rpar);

    // Sticky parity error; also visible combinationally in the DONE cycle.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            parErr_q <= 1'b0;
        end else if (par_bad) begin
            parErr_q <= 1'b1;
        end
    end

    assign parErr = parErr_q | par_bad;

    mm_byte_array #(
        .AW (memAW),
        .DW (dataWIDTH)
    ) u_array (
        .clk_i   (CLK),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (adr_q),
        .wdata_i (wdata_q),
        .rdata_o (rdata),
        .wpar_i  (wpar),
        .rpar_o  (rpar)
    );
`else
    mm_byte_array #(
        .AW (memAW),
        .DW (dataWIDTH)
    ) u_array (
        .clk_i   (CLK),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (adr_q),
        .wdata_i (wdata_q),
        .rdata_o (rdata)
    );
`endif

endmodule

// File: tb/tb_main_mem_if.sv
// Bench for main_mem_if: directed scenarios plus a randomized access stream
// checked against an associative-array memory model and simple counters.
module tb_main_mem_if;

    localparam int LAT = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] adrMM = '0;
    logic        readMem = 1'b0;
    logic        writeMem = 1'b0;
    wire  [7:0]  dataMM;
    logic        readyMem;
    logic        busErr;
    logic [15:0] rdCount;
    logic [15:0] wrCount;
    logic [7:0]  tb_dq = '0;
    logic        tb_oe = 1'b0;

    logic [15:0] adr1 = '0;
    logic        rd1 = 1'b0;
    wire  [7:0]  data1;
    logic        ready1;
    logic        busErr1;
    logic [15:0] rdCount1;
    logic [15:0] wrCount1;

`ifdef MAIN_MEM_PARITY_EN
    logic parErr;
    logic injPar = 1'b0;
    logic parErr1;
    logic par_done = 1'b0;
`endif

    assign dataMM = tb_oe ? tb_dq : 8'bz;

    always #5 CLK = ~CLK;

    main_mem_if #(.adrWIDTH(16), .dataWIDTH(8), .memAW(16), .LATENCY(LAT)) u_dut (
        .CLK      (CLK),
        .RST      (RST),
        .adrMM    (adrMM),
        .dataMM   (dataMM),
        .readMem  (readMem),
        .writeMem (writeMem),
        .readyMem (readyMem),
        .busErr   (busErr),
        .rdCount  (rdCount),
        .wrCount  (wrCount)
`ifdef MAIN_MEM_PARITY_EN
        ,
        .parErr   (parErr),
        .injPar   (injPar)
`endif
    );

    main_mem_if #(.adrWIDTH(16), .dataWIDTH(8), .memAW(8), .LATENCY(1)) u_lat1 (
        .CLK      (CLK),
        .RST      (RST),
        .adrMM    (adr1),
        .dataMM   (data1),
        .readMem  (rd1),
        .writeMem (1'b0),
        .readyMem (ready1),
        .busErr   (busErr1),
        .rdCount  (rdCount1),
        .wrCount  (wrCount1)
`ifdef MAIN_MEM_PARITY_EN
        ,
        .parErr   (parErr1),
        .injPar   (1'b0)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: byte memory plus completion statistics.
    logic [7:0] mem_m [int];
    int         rd_m = 0;
    int         wr_m = 0;
    logic       busErr_m = 1'b0;

    // Issue one request from IDLE (called just after a negedge) and observe
    // the number of not-ready cycles and the bus value in the ready cycle.
    // Returns just after the negedge of the following IDLE cycle.
    task automatic do_access(input logic wr, input logic rd, input logic [15:0] adr,
                             input logic [7:0] wd, output int low, output logic [7:0] rdat);
        adrMM    = adr;
        writeMem = wr;
        readMem  = rd;
        tb_dq    = wd;
        tb_oe    = wr;
        @(posedge CLK);
        @(negedge CLK);
        writeMem = 1'b0;
        readMem  = 1'b0;
        tb_oe    = 1'b0;
        low = 0;
        while (readyMem === 1'b0 && low < 40) begin
            low++;
            @(negedge CLK);
        end
        rdat = dataMM;
`ifdef MAIN_MEM_PARITY_EN
        par_done = parErr;
`endif
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        tb_oe = 1'b1;
        tb_dq = 8'h5A;
        #1;
        n_vec++;
        if (dataMM !== 8'h5A) begin
            n_err++;
            $display("FAIL reset_bus_z: got %h want %h", dataMM, 8'h5A);
        end
        tb_oe = 1'b0;
        n_vec++;
        if ({readyMem, busErr} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_flags: ready/busErr got %b want 10", {readyMem, busErr});
        end
        n_vec++;
        if (rdCount !== 16'd0 || wrCount !== 16'd0) begin
            n_err++;
            $display("FAIL reset_counts: got rd=%0d wr=%0d want 0 0", rdCount, wrCount);
        end
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_write_read();
        int low;
        logic [7:0] r;
        do_access(1'b1, 1'b0, 16'h0010, 8'hA5, low, r);
        mem_m[16'h0010] = 8'hA5;
        wr_m++;
        n_vec++;
        if (low != LAT) begin
            n_err++;
            $display("FAIL wr_latency: got %0d low cycles want %0d", low, LAT);
        end
        n_vec++;
        if (wrCount !== 16'(wr_m)) begin
            n_err++;
            $display("FAIL wr_count: got %0d want %0d", wrCount, wr_m);
        end
        do_access(1'b0, 1'b1, 16'h0010, 8'h00, low, r);
        rd_m++;
        n_vec++;
        if (low != LAT) begin
            n_err++;
            $display("FAIL rd_latency: got %0d low cycles want %0d", low, LAT);
        end
        n_vec++;
        if (r !== 8'hA5) begin
            n_err++;
            $display("FAIL rd_data: got %h want %h", r, 8'hA5);
        end
        tb_oe = 1'b1;
        tb_dq = 8'h5A;
        #1;
        n_vec++;
        if (dataMM !== 8'h5A) begin
            n_err++;
            $display("FAIL rd_release: bus got %h want %h (driver still on)", dataMM, 8'h5A);
        end
        tb_oe = 1'b0;
        n_vec++;
        if (rdCount !== 16'(rd_m)) begin
            n_err++;
            $display("FAIL rd_count: got %0d want %0d", rdCount, rd_m);
        end
    endtask

    task automatic test_abort();
        int low;
        logic [7:0] r;
        do_access(1'b1, 1'b0, 16'h0030, 8'h00, low, r);
        mem_m[16'h0030] = 8'h00;
        wr_m++;
        adrMM    = 16'h0030;
        writeMem = 1'b1;
        tb_dq    = 8'hFF;
        tb_oe    = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        writeMem = 1'b0;
        tb_oe    = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        n_vec++;
        if (readyMem !== 1'b0) begin
            n_err++;
            $display("FAIL abort_in_access: ready got %b want 0", readyMem);
        end
        RST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        rd_m = 0;
        wr_m = 0;
        busErr_m = 1'b0;
        n_vec++;
        if (readyMem !== 1'b1) begin
            n_err++;
            $display("FAIL abort_idle: ready got %b want 1", readyMem);
        end
        repeat (LAT + 2) @(negedge CLK);
        n_vec++;
        if (wrCount !== 16'd0 || readyMem !== 1'b1) begin
            n_err++;
            $display("FAIL abort_settle: got wr=%0d ready=%b want 0 1", wrCount, readyMem);
        end
        do_access(1'b0, 1'b1, 16'h0030, 8'h00, low, r);
        rd_m++;
        n_vec++;
        if (r !== 8'h00) begin
            n_err++;
            $display("FAIL abort_no_commit: got %h want %h", r, 8'h00);
        end
    endtask

    task automatic test_bus_err();
        int low;
        logic [7:0] r;
        do_access(1'b1, 1'b1, 16'h0020, 8'h3C, low, r);
        mem_m[16'h0020] = 8'h3C;
        wr_m++;
        busErr_m = 1'b1;
        n_vec++;
        if (busErr !== busErr_m || wrCount !== 16'(wr_m) || rdCount !== 16'(rd_m)) begin
            n_err++;
            $display("FAIL buserr_write: got err=%b wr=%0d rd=%0d want %b %0d %0d",
                     busErr, wrCount, rdCount, busErr_m, wr_m, rd_m);
        end
        do_access(1'b0, 1'b1, 16'h0020, 8'h00, low, r);
        rd_m++;
        n_vec++;
        if (r !== 8'h3C || busErr !== 1'b1) begin
            n_err++;
            $display("FAIL buserr_readback: got %h err=%b want 3c 1", r, busErr);
        end
    endtask

    task automatic test_random();
        int low;
        logic [7:0] r;
        logic [15:0] a;
        logic [7:0] d;
        int kind;
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            do_access(1'b1, 1'b0, 16'h0100 + 16'(i), d, low, r);
            mem_m[16'h0100 + i] = d;
            wr_m++;
        end
        for (int i = 0; i < 40; i++) begin
            a    = 16'h0100 + 16'($urandom_range(0, 7));
            d    = 8'($urandom);
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                do_access(1'b1, 1'b1, a, d, low, r);
                mem_m[int'(a)] = d;
                wr_m++;
                busErr_m = 1'b1;
            end else if (kind < 5) begin
                do_access(1'b1, 1'b0, a, d, low, r);
                mem_m[int'(a)] = d;
                wr_m++;
            end else begin
                do_access(1'b0, 1'b1, a, 8'h00, low, r);
                rd_m++;
                n_vec++;
                if (r !== mem_m[int'(a)]) begin
                    n_err++;
                    $display("FAIL rand_rd_data[%0d]: adr %h got %h want %h",
                             i, a, r, mem_m[int'(a)]);
                end
            end
            n_vec++;
            if (low != LAT) begin
                n_err++;
                $display("FAIL rand_latency[%0d]: got %0d want %0d", i, low, LAT);
            end
            n_vec++;
            if (rdCount !== 16'(rd_m) || wrCount !== 16'(wr_m) || busErr !== busErr_m) begin
                n_err++;
                $display("FAIL rand_stats[%0d]: got rd=%0d wr=%0d err=%b want %0d %0d %b",
                         i, rdCount, wrCount, busErr, rd_m, wr_m, busErr_m);
            end
        end
    endtask

    task automatic test_back_to_back_lat1();
        logic exp_ready;
        @(negedge CLK);
        rd1 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge CLK);
            exp_ready = (i % 3 == 0) ? 1'b0 : 1'b1;
            n_vec++;
            if (ready1 !== exp_ready) begin
                n_err++;
                $display("FAIL lat1_ready[%0d]: got %b want %b", i, ready1, exp_ready);
            end
        end
        rd1 = 1'b0;
        n_vec++;
        if (rdCount1 !== 16'd3) begin
            n_err++;
            $display("FAIL lat1_rdcount: got %0d want 3", rdCount1);
        end
    endtask

`ifdef MAIN_MEM_PARITY_EN
    task automatic test_parity();
        int low;
        logic [7:0] r;
        do_access(1'b1, 1'b0, 16'h0040, 8'h07, low, r);
        do_access(1'b0, 1'b1, 16'h0040, 8'h00, low, r);
        n_vec++;
        if (par_done !== 1'b0) begin
            n_err++;
            $display("FAIL par_clean: parErr got %b want 0", par_done);
        end
        injPar = 1'b1;
        do_access(1'b1, 1'b0, 16'h0041, 8'h01, low, r);
        injPar = 1'b0;
        do_access(1'b0, 1'b1, 16'h0041, 8'h00, low, r);
        n_vec++;
        if (par_done !== 1'b1 || r !== 8'h01) begin
            n_err++;
            $display("FAIL par_detect: got err=%b data=%h want 1 01", par_done, r);
        end
        repeat (3) @(negedge CLK);
        n_vec++;
        if (parErr !== 1'b1) begin
            n_err++;
            $display("FAIL par_sticky: got %b want 1", parErr);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_abort();
        test_bus_err();
        test_random();
        test_back_to_back_lat1();
`ifdef MAIN_MEM_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
